icm_get_proc_thread_1: RTL and testbench
========================================

Name: icm_get_proc_thread_1

Overview:
- Front stage of the ICM cache get path.
- Accepts get requests carrying an ICM virtual address, a request tag and an entry count.
- Translates each covered entry's ICM address to a host physical address through the ICM page mapping table (synchronous RAM, 1-cycle read).
- Pushes one packed record per entry into the ReqFIFO. The downstream get-issue thread drains that FIFO into the cache.

Parameters:
- ICM_ADDR_WIDTH, 64, width of ICM virtual address.
- PHYSICAL_ADDR_WIDTH, 48, width of host physical address.
- ICM_PAGE_NUM, 8192, number of mapped ICM pages (4 KB each).
- ICM_PAGE_NUM_LOG, 13, log2 of ICM_PAGE_NUM.
- ICM_SLOT_SIZE, 32, bytes per cache entry; address stride between split entries.
- COUNT_MAX, 2, maximum entries per request.
- COUNT_MAX_LOG, 2, width of count/index fields.
- REQ_TAG_WIDTH, 5, width of request tag.
- HEAD_WIDTH, 2*COUNT_MAX_LOG+REQ_TAG_WIDTH+PHYSICAL_ADDR_WIDTH+ICM_ADDR_WIDTH, ReqFIFO record width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- get_req_valid  input  1  request valid
- get_req_count  input  COUNT_MAX_LOG  entries requested (0 treated as 1; values >COUNT_MAX clamp to COUNT_MAX)
- get_req_tag  input  REQ_TAG_WIDTH  requester tag
- get_req_icm_addr  input  ICM_ADDR_WIDTH  ICM address of first entry
- get_req_ready  output  1  request accept
- page_tbl_rd_en  output  1  mapping table read strobe
- page_tbl_rd_addr  output  ICM_PAGE_NUM_LOG  page index = icm_addr[12+ICM_PAGE_NUM_LOG-1:12]
- page_tbl_rd_dout  input  1+PHYSICAL_ADDR_WIDTH-12  {valid, phy_page_base}; valid the cycle after rd_en
- req_fifo_wr_en  output  1  ReqFIFO push
- req_fifo_din  output  HEAD_WIDTH  {count, index, tag, phy_addr, icm_addr}, MSB first
- req_fifo_full  input  1  ReqFIFO full
- map_err  output  1  1-cycle pulse on unmapped page

Behaviour:
- The interface uses one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, get_req_ready 0, FSM in IDLE. Reset mid-operation discards any partially issued request. Records already pushed stay pushed.
- FSM states: IDLE, RD, WAIT, PUSH.
  - IDLE: get_req_ready=1. On valid&&ready, latch tag, clamped count, addr; set index=0; go RD.
  - RD: page_tbl_rd_en=1 with page index of the current addr; go WAIT.
  - WAIT: sample dout.
    - If valid=1: register phy_addr={phy_page_base, addr[11:0]} and the record; go PUSH.
    - If valid=0: pulse map_err, drop the whole remaining request, go IDLE.
  - PUSH: req_fifo_wr_en = ~req_fifo_full; hold the record stable while full.
    - On push with index+1<count: addr+=ICM_SLOT_SIZE (64-bit wrap), index++, go RD.
    - Otherwise go IDLE.
- Latency: the request accepted at cycle 0 is pushed at the earliest at cycle 3. Each further entry takes 3 cycles.
- Record fields:
  - count = clamped count.
  - index = 0-based entry number.
  - icm_addr = that entry's ICM address.
- The page crossing on the second entry is handled naturally because every entry performs its own lookup.
- get_req_ready is 0 in every state except IDLE. The next request is accepted only once the FSM is back in IDLE: a request accepted at cycle 0 with count=1 and no stalls returns to IDLE at cycle 4, so the next accept is at cycle 4 at the earliest.
- req_fifo_wr_en never asserts while req_fifo_full=1.

Test Plan:
- Page 5 mapped to base 0x12345; count=1, tag=3, addr=0x5040 -> one push at cycle 3: count=1, index=0, tag=3, phy=0x12345040, icm=0x5040; ready returns high.
- count=2, addr=0x5FE0, page5->0x10000, page6->0x20000 -> push1 phy=0x10000FE0 idx0, push2 phy=0x20000000 idx1 icm=0x6000.
- req_fifo_full high for 10 cycles at PUSH -> wr_en stays 0, din stable; push occurs the cycle full drops.
- Page 7 invalid, count=2 -> map_err pulses once, zero pushes, FSM returns to IDLE, next request is accepted.
- count=0 and count=3 with COUNT_MAX=2 -> exactly 1 and 2 pushes respectively.
- Assert rst during the WAIT of entry 2 -> outputs 0 immediately, only entry 1 in FIFO; after release a new request completes normally.

Source files
------------

// File: rtl/icm_get_proc_thread_1.sv
// ICM get path front stage: takes a get request, looks up each entry's host
// page in the mapping table and pushes one packed record per entry to the ReqFIFO.
module icm_get_proc_thread_1 #(
    parameter int ICM_ADDR_WIDTH      = 64,
    parameter int PHYSICAL_ADDR_WIDTH = 48,
    parameter int ICM_PAGE_NUM        = 8192,
    parameter int ICM_PAGE_NUM_LOG    = 13,
    parameter int ICM_SLOT_SIZE       = 32,
    parameter int COUNT_MAX           = 2,
    parameter int COUNT_MAX_LOG       = 2,
    parameter int REQ_TAG_WIDTH       = 5,
    parameter int HEAD_WIDTH          = 2*COUNT_MAX_LOG + REQ_TAG_WIDTH + PHYSICAL_ADDR_WIDTH + ICM_ADDR_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              get_req_valid,
    input  logic [COUNT_MAX_LOG-1:0]          get_req_count,
    input  logic [REQ_TAG_WIDTH-1:0]          get_req_tag,
    input  logic [ICM_ADDR_WIDTH-1:0]         get_req_icm_addr,
    output logic                              get_req_ready,
    output logic                              page_tbl_rd_en,
    output logic [ICM_PAGE_NUM_LOG-1:0]       page_tbl_rd_addr,
    input  logic [PHYSICAL_ADDR_WIDTH-12:0]   page_tbl_rd_dout,
    output logic                              req_fifo_wr_en,
    output logic [HEAD_WIDTH-1:0]             req_fifo_din,
    input  logic                              req_fifo_full,
    output logic                              map_err
);

    // state | meaning
    // IDLE  | ready for a new request
    // RD    | mapping table read strobe for the current entry
    // WAIT  | table data returning; build record or abort on unmapped page
    // PUSH  | record presented to the ReqFIFO, held while it is full
    typedef enum logic [1:0] {IDLE, RD, WAIT, PUSH} state_t;

    localparam int DOUT_WIDTH = PHYSICAL_ADDR_WIDTH - 11;

    state_t                          state;
    logic [COUNT_MAX_LOG-1:0]        cnt;
    logic [COUNT_MAX_LOG-1:0]        idx;
    logic [REQ_TAG_WIDTH-1:0]        tag;
    logic [ICM_ADDR_WIDTH-1:0]       addr;
    logic                            ready_q;
    logic                            rd_en_q;
    logic [ICM_PAGE_NUM_LOG-1:0]     rd_addr_q;
    logic                            map_err_q;
    logic [HEAD_WIDTH-1:0]           din_q;

    logic [COUNT_MAX_LOG-1:0]        count_clamped;
    logic [ICM_ADDR_WIDTH-1:0]       next_addr;
    logic [COUNT_MAX_LOG-1:0]        next_idx;
    logic                            page_valid;
    logic [DOUT_WIDTH-2:0]           page_base;

    // A zero count still means one entry; anything above COUNT_MAX saturates.
    always_comb begin
        count_clamped = get_req_count;
        if (get_req_count == '0)
            count_clamped = COUNT_MAX_LOG'(1);
        else if (get_req_count > COUNT_MAX_LOG'(COUNT_MAX))
            count_clamped = COUNT_MAX_LOG'(COUNT_MAX);
    end

    assign next_addr  = addr + ICM_ADDR_WIDTH'(ICM_SLOT_SIZE);
    assign next_idx   = idx + COUNT_MAX_LOG'(1);
    assign page_valid = page_tbl_rd_dout[DOUT_WIDTH-1];
    assign page_base  = page_tbl_rd_dout[DOUT_WIDTH-2:0];

    // Push is gated combinationally so it can never coincide with full.
    assign req_fifo_wr_en   = (state == PUSH) && !req_fifo_full;
    assign get_req_ready    = ready_q;
    assign page_tbl_rd_en   = rd_en_q;
    assign page_tbl_rd_addr = rd_addr_q;
    assign map_err          = map_err_q;
    assign req_fifo_din     = din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            tag       <= '0;
            addr      <= '0;
            ready_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            map_err_q <= 1'b0;
            din_q     <= '0;
        end else begin
            rd_en_q   <= 1'b0;
            map_err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (get_req_valid) begin
                        ready_q   <= 1'b0;
                        cnt       <= count_clamped;
                        idx       <= '0;
                        tag       <= get_req_tag;
                        addr      <= get_req_icm_addr;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= get_req_icm_addr[12+ICM_PAGE_NUM_LOG-1:12];
                        state     <= RD;
                    end
                end
                RD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (page_valid) begin
                        din_q <= {cnt, idx, tag, page_base, addr[11:0], addr};
                        state <= PUSH;
                    end else begin
                        map_err_q <= 1'b1;
                        ready_q   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                PUSH: begin
                    if (!req_fifo_full) begin
                        if (next_idx < cnt) begin
                            addr      <= next_addr;
                            idx       <= next_idx;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= next_addr[12+ICM_PAGE_NUM_LOG-1:12];
                            state     <= RD;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icm_get_proc_thread_1.sv
// Directed bench for icm_get_proc_thread_1: expected ReqFIFO records are queued
// at issue time and a negedge monitor pops and compares every push.
module tb_icm_get_proc_thread_1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         get_req_valid = 1'b0;
    logic [1:0]   get_req_count = '0;
    logic [4:0]   get_req_tag = '0;
    logic [63:0]  get_req_icm_addr = '0;
    logic         get_req_ready;
    logic         page_tbl_rd_en;
    logic [12:0]  page_tbl_rd_addr;
    logic [36:0]  page_tbl_rd_dout = '0;
    logic         req_fifo_wr_en;
    logic [120:0] req_fifo_din;
    logic         req_fifo_full = 1'b0;
    logic         map_err;

    icm_get_proc_thread_1 dut (
        .clk              (clk),
        .rst              (rst),
        .get_req_valid    (get_req_valid),
        .get_req_count    (get_req_count),
        .get_req_tag      (get_req_tag),
        .get_req_icm_addr (get_req_icm_addr),
        .get_req_ready    (get_req_ready),
        .page_tbl_rd_en   (page_tbl_rd_en),
        .page_tbl_rd_addr (page_tbl_rd_addr),
        .page_tbl_rd_dout (page_tbl_rd_dout),
        .req_fifo_wr_en   (req_fifo_wr_en),
        .req_fifo_din     (req_fifo_din),
        .req_fifo_full    (req_fifo_full),
        .map_err          (map_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push_cnt = 0;
    int last_push_cyc = -1;
    int err_pulses = 0;
    logic [120:0] exp_q[$];
    logic [35:0]  page_map [int];

    always @(posedge clk) cyc <= cyc + 1;

    // Mapping table model: one-cycle synchronous read, unmapped pages read as invalid.
    always @(posedge clk) begin
        if (page_tbl_rd_en) begin
            if (page_map.exists(int'(page_tbl_rd_addr)))
                page_tbl_rd_dout <= {1'b1, page_map[int'(page_tbl_rd_addr)]};
            else
                page_tbl_rd_dout <= '0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (req_fifo_full) begin
                checks++;
                if (req_fifo_wr_en) begin
                    errors++;
                    $display("FAIL wr_en_while_full: wr_en=%0b required 0 at cycle %0d", req_fifo_wr_en, cyc);
                end
            end
            if (req_fifo_wr_en) begin
                push_cnt++;
                last_push_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_push: din=%0h with no record expected", req_fifo_din);
                end else begin
                    logic [120:0] e;
                    e = exp_q.pop_front();
                    if (req_fifo_din !== e) begin
                        errors++;
                        $display("FAIL record: got %0h required %0h", req_fifo_din, e);
                    end
                end
            end
            if (map_err) err_pulses++;
        end
    end

    function automatic logic [120:0] mk(logic [1:0] c, logic [1:0] i, logic [4:0] t,
                                        logic [47:0] p, logic [63:0] a);
        return {c, i, t, p, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [4:0] t, input logic [63:0] a, output int acc);
        int n = 0;
        while (!get_req_ready && n < 50) begin
            step();
            n++;
        end
        if (!get_req_ready) begin
            errors++;
            $display("FAIL accept_timeout: ready=%0b required 1", get_req_ready);
        end
        get_req_valid    = 1'b1;
        get_req_count    = c;
        get_req_tag      = t;
        get_req_icm_addr = a;
        acc = cyc;
        step();
        get_req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk(name, 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        int p0;
        int e0;

        step();
        chk("rst_ready", 128'(get_req_ready), 128'd0);
        chk("rst_wr_en", 128'(req_fifo_wr_en), 128'd0);
        chk("rst_rd_en", 128'(page_tbl_rd_en), 128'd0);
        chk("rst_din", 128'(req_fifo_din), 128'd0);
        chk("rst_map_err", 128'(map_err), 128'd0);
        step();
        rst = 1'b0;

        // single entry, latency and ready return
        page_map[5] = 36'h12345;
        exp_q.push_back(mk(2'd1, 2'd0, 5'd3, 48'h12345040, 64'h5040));
        send(2'd1, 5'd3, 64'h5040, a);
        step(); step(); step();
        chk("t1_latency", 128'(last_push_cyc), 128'(a + 3));
        chk("t1_ready", 128'(get_req_ready), 128'd1);
        chk("t1_drained", 128'(exp_q.size()), 128'd0);

        // two entries crossing a page boundary
        page_map[5] = 36'h10000;
        page_map[6] = 36'h20000;
        exp_q.push_back(mk(2'd2, 2'd0, 5'd7, 48'h10000FE0, 64'h5FE0));
        exp_q.push_back(mk(2'd2, 2'd1, 5'd7, 48'h20000000, 64'h6000));
        send(2'd2, 5'd7, 64'h5FE0, a);
        drain("t2_drain");
        chk("t2_second_latency", 128'(last_push_cyc), 128'(a + 6));

        // FIFO full for ten cycles while the record waits
        page_map[5] = 36'h12345;
        p0 = push_cnt;
        exp_q.push_back(mk(2'd1, 2'd0, 5'd9, 48'h12345100, 64'h5100));
        send(2'd1, 5'd9, 64'h5100, a);
        req_fifo_full = 1'b1;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            chk("t3_wr_en_held", 128'(req_fifo_wr_en), 128'd0);
            chk("t3_din_stable", 128'(req_fifo_din), 128'(mk(2'd1, 2'd0, 5'd9, 48'h12345100, 64'h5100)));
            step();
        end
        req_fifo_full = 1'b0;
        step();
        chk("t3_push_cycle", 128'(last_push_cyc), 128'(a + 13));
        chk("t3_push_count", 128'(push_cnt - p0), 128'd1);

        // unmapped page aborts the whole request
        p0 = push_cnt;
        e0 = err_pulses;
        send(2'd2, 5'd1, 64'h7000, a);
        step(); step(); step();
        chk("t4_map_err", 128'(err_pulses - e0), 128'd1);
        chk("t4_no_push", 128'(push_cnt - p0), 128'd0);
        chk("t4_ready", 128'(get_req_ready), 128'd1);
        exp_q.push_back(mk(2'd1, 2'd0, 5'd2, 48'h12345000, 64'h5000));
        send(2'd1, 5'd2, 64'h5000, a);
        drain("t4_next_drain");

        // count clamping
        p0 = push_cnt;
        exp_q.push_back(mk(2'd1, 2'd0, 5'd4, 48'h12345010, 64'h5010));
        send(2'd0, 5'd4, 64'h5010, a);
        drain("t5_count0_drain");
        chk("t5_count0_pushes", 128'(push_cnt - p0), 128'd1);
        p0 = push_cnt;
        exp_q.push_back(mk(2'd2, 2'd0, 5'd5, 48'h12345020, 64'h5020));
        exp_q.push_back(mk(2'd2, 2'd1, 5'd5, 48'h12345040, 64'h5040));
        send(2'd3, 5'd5, 64'h5020, a);
        drain("t5_count3_drain");
        chk("t5_count3_pushes", 128'(push_cnt - p0), 128'd2);

        // reset during the lookup of entry 2
        p0 = push_cnt;
        exp_q.push_back(mk(2'd2, 2'd0, 5'd6, 48'h12345000, 64'h5000));
        exp_q.push_back(mk(2'd2, 2'd1, 5'd6, 48'h12345020, 64'h5020));
        send(2'd2, 5'd6, 64'h5000, a);
        step(); step(); step(); step();
        rst = 1'b1;
        #1;
        chk("t6_wr_en", 128'(req_fifo_wr_en), 128'd0);
        chk("t6_rd_en", 128'(page_tbl_rd_en), 128'd0);
        chk("t6_ready", 128'(get_req_ready), 128'd0);
        chk("t6_din", 128'(req_fifo_din), 128'd0);
        chk("t6_map_err", 128'(map_err), 128'd0);
        chk("t6_one_push", 128'(push_cnt - p0), 128'd1);
        chk("t6_outstanding", 128'(exp_q.size()), 128'd1);
        exp_q.delete();
        step(); step();
        rst = 1'b0;
        exp_q.push_back(mk(2'd1, 2'd0, 5'd8, 48'h20000060, 64'h6060));
        send(2'd1, 5'd8, 64'h6060, a);
        drain("t6_after_reset_drain");

        step(); step();
        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
        chk("final_map_err_total", 128'(err_pulses), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
